// File: rtl/ofmap_bram_drain.sv
// Drains every word of the Ofmap BRAM (mem2) through port 1 into a valid/ready stream.
// Define OFMAP_DRAIN_LANE_REV_EN to reverse the byte lanes of m_data_o.
module ofmap_bram_drain #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned MEM2_DATA_WIDTH = 112,
  parameter int unsigned MEM2_DEPTH      = 896,
  parameter int unsigned MEM2_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  output logic                       mem2_ce1,
  output logic                       mem2_we1,
  output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr1,
  input  logic [MEM2_DATA_WIDTH-1:0] mem2_q1_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [MEM2_DATA_WIDTH-1:0] m_data_o,
  output logic                       m_last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned Lanes = MEM2_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned CntW  = $clog2(MEM2_DEPTH + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(MEM2_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            rd_addr_q, rd_addr_d;
  logic [CntW-1:0]            out_cnt_q, out_cnt_d;
  logic                       inflight_q, inflight_d;
  logic [MEM2_DATA_WIDTH-1:0] fifo_q [2];
  logic [MEM2_DATA_WIDTH-1:0] fifo_d [2];
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0]                 count_q, count_d;

  logic                       issue;
  logic                       pop;
  logic [2:0]                 occ;
  logic [MEM2_DATA_WIDTH-1:0] head;
  logic [MEM2_DATA_WIDTH-1:0] head_ordered;

  assign m_valid_o = (count_q != 2'd0);
  assign head      = fifo_q[rd_ptr_q];
  assign m_last_o  = m_valid_o && (out_cnt_q == LastIdx);
  assign m_data_o  = m_valid_o ? head_ordered : '0;
  assign pop       = m_valid_o && m_ready_i;

  // The slot freed by this cycle's pop counts as free, which sustains 1 word/clk.
  assign occ   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign issue = (state_q == StRead) && (occ < 3'd2);

  assign mem2_ce1   = issue;
  assign mem2_we1   = 1'b0;
  assign mem2_addr1 = issue ? MEM2_ADDR_WIDTH'(rd_addr_q) : '0;
  assign busy_o     = (state_q == StRead) || (state_q == StDrain);
  assign done_o     = (state_q == StDone);

`ifdef OFMAP_DRAIN_LANE_REV_EN
  for (genvar l = 0; l < Lanes; l++) begin : g_lane_rev
    assign head_ordered[l*DATA_WIDTH +: DATA_WIDTH] =
        head[(Lanes-1-l)*DATA_WIDTH +: DATA_WIDTH];
  end
`else
  assign head_ordered = head;
`endif

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    out_cnt_d  = out_cnt_q;
    inflight_d = issue;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + 2'(inflight_q) - 2'(pop);

    if (issue) begin
      rd_addr_d = rd_addr_q + CntW'(1);
    end
    // Read data arrives one cycle after the issuing ce.
    if (inflight_q) begin
      fifo_d[wr_ptr_q] = mem2_q1_i;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      out_cnt_d = out_cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StRead;
          rd_addr_d = '0;
          out_cnt_d = '0;
        end
      end
      StRead: begin
        if (issue && (rd_addr_q == LastIdx)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && m_last_o) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d   = StIdle;
        rd_addr_d = '0;
        out_cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_addr_q  <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(inflight_q && !pop && (count_q == 2'd2)));

endmodule
